// File: rtl/pwm_carrier_generator.sv
// -----------------------------------------------------------------------------
// pwm_carrier_generator
//
// Produces the modulated IR carrier for the LED driver. The carrier is a 50%
// duty square wave. Each half-period lasts (value+1)*PRESCALE clocks, where
// value is the half-period word written by the playback controller. New words
// land in a shadow register and are moved into the active register either
// immediately (while idle) or at a half-period reload (while running), so the
// half-period in progress is never cut short or stretched.
//
// Ports:
//   clock_in          system clock
//   reset_n_in        asynchronous reset, active low
//   pwm_enable_in     run the modulated carrier while high
//   pwm_forced_in     LED continuously on while high and enable is low
//   pwm_wr_strobe_in  capture pwm_value_in this cycle
//   pwm_value_in      new half-period word (ticks minus one)
//   pwm_wr_ack_out    one-cycle pulse, the cycle after each capture
//   ir_out            registered carrier / LED drive
//   carrier_busy_out  high while the carrier FSM is in RUN; this is also the
//                     FSM state view for checkers (IDLE=0, RUN=1)
//
// Write handshake: a strobe is a single-cycle request with no back-pressure.
// Every cycle the strobe is high is one capture; the ack answers it exactly
// one cycle later. A held strobe captures every cycle and the last word wins.
// -----------------------------------------------------------------------------
module pwm_carrier_generator #(
  parameter int PWM_BITS        = 8,
  parameter int PRESCALE        = 1,
  parameter bit IR_ACTIVE_LEVEL = 1'b1
) (
  input  logic                clock_in,
  input  logic                reset_n_in,
  input  logic                pwm_enable_in,
  input  logic                pwm_forced_in,
  input  logic                pwm_wr_strobe_in,
  input  logic [PWM_BITS-1:0] pwm_value_in,
  output logic                pwm_wr_ack_out,
  output logic                ir_out,
  output logic                carrier_busy_out
);

  localparam int PW = $clog2(PRESCALE) + 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
  localparam logic ACT = IR_ACTIVE_LEVEL;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t              r_state;
  logic [PWM_BITS-1:0] r_shadow;
  logic [PWM_BITS-1:0] r_active;
  logic                r_pending;
  logic                r_phase;
  logic [PWM_BITS-1:0] r_cnt;
  logic [PW-1:0]       r_pre;
  logic                r_ack;
  logic                r_ir;

  logic                w_tick;
  logic [PWM_BITS-1:0] w_reload_val;
  logic [PWM_BITS-1:0] w_start_val;

  always_comb begin
    w_tick       = (r_pre == PRE_LAST);
    w_reload_val = r_pending ? r_shadow : r_active;
    // A write arriving on the very edge the carrier starts is used straight
    // away, so the first half-period never runs with the stale word.
    w_start_val  = pwm_wr_strobe_in ? pwm_value_in : w_reload_val;
  end

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_state   <= ST_IDLE;
      r_shadow  <= '0;
      r_active  <= '0;
      r_pending <= 1'b0;
      r_phase   <= 1'b0;
      r_cnt     <= '0;
      r_pre     <= '0;
      r_ack     <= 1'b0;
      r_ir      <= !ACT;
    end else begin
      r_ack <= pwm_wr_strobe_in;

      // Output follows the registered state/phase one cycle later;
      // enable (RUN) takes priority over forced.
      if (r_state == ST_RUN) begin
        r_ir <= r_phase ? ACT : !ACT;
      end else begin
        r_ir <= pwm_forced_in ? ACT : !ACT;
      end

      // Capture. Transfers below clear pending only when no new word arrives
      // in the same cycle, so a fresh write is never lost.
      if (pwm_wr_strobe_in) begin
        r_shadow  <= pwm_value_in;
        r_pending <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          r_cnt   <= '0;
          r_pre   <= '0;
          r_phase <= 1'b0;
          if (pwm_enable_in) begin
            r_state   <= ST_RUN;
            r_phase   <= 1'b1;
            r_cnt     <= w_start_val;
            r_active  <= w_start_val;
            r_pending <= 1'b0;
          end else if (r_pending) begin
            r_active <= r_shadow;
            if (!pwm_wr_strobe_in) r_pending <= 1'b0;
          end
        end

        ST_RUN: begin
          if (!pwm_enable_in) begin
            r_state <= ST_IDLE;
            r_phase <= 1'b0;
            r_cnt   <= '0;
            r_pre   <= '0;
            if (r_pending) begin
              r_active <= r_shadow;
              if (!pwm_wr_strobe_in) r_pending <= 1'b0;
            end
          end else if (w_tick) begin
            r_pre <= '0;
            if (r_cnt == '0) begin
              // Half-period boundary: the only point a new word may take hold.
              r_phase <= ~r_phase;
              r_cnt   <= w_reload_val;
              if (r_pending) begin
                r_active <= r_shadow;
                if (!pwm_wr_strobe_in) r_pending <= 1'b0;
              end
            end else begin
              r_cnt <= r_cnt - PWM_BITS'(1);
            end
          end else begin
            r_pre <= r_pre + PW'(1);
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign pwm_wr_ack_out   = r_ack;
  assign ir_out           = r_ir;
  assign carrier_busy_out = (r_state == ST_RUN);

endmodule

// File: tb/tb_pwm_carrier_generator.sv
// -----------------------------------------------------------------------------
// Bench for pwm_carrier_generator. Two instances share the stimulus: one with
// PRESCALE=1 and one with PRESCALE=4. Expected {ir, ack, busy} triples are
// pushed per cycle by the driver and popped by a monitor 1 ns after each
// rising edge.
// -----------------------------------------------------------------------------
module tb_pwm_carrier_generator;

  // ---------------- clock / reset ----------------
  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       en    = 1'b0;
  logic       frc   = 1'b0;
  logic       stb   = 1'b0;
  logic [7:0] val   = 8'd0;

  always #5 clk = ~clk;

  logic ir1, ack1, busy1;
  logic ir4, ack4, busy4;

  pwm_carrier_generator #(.PWM_BITS(8), .PRESCALE(1), .IR_ACTIVE_LEVEL(1'b1)) d1 (
    .clock_in         (clk),
    .reset_n_in       (rst_n),
    .pwm_enable_in    (en),
    .pwm_forced_in    (frc),
    .pwm_wr_strobe_in (stb),
    .pwm_value_in     (val),
    .pwm_wr_ack_out   (ack1),
    .ir_out           (ir1),
    .carrier_busy_out (busy1)
  );

  pwm_carrier_generator #(.PWM_BITS(8), .PRESCALE(4), .IR_ACTIVE_LEVEL(1'b1)) d4 (
    .clock_in         (clk),
    .reset_n_in       (rst_n),
    .pwm_enable_in    (en),
    .pwm_forced_in    (frc),
    .pwm_wr_strobe_in (stb),
    .pwm_value_in     (val),
    .pwm_wr_ack_out   (ack4),
    .ir_out           (ir4),
    .carrier_busy_out (busy4)
  );

  // Expected encodings: {ir, ack, busy}
  localparam logic [2:0] IDL   = 3'b000;
  localparam logic [2:0] ACKI  = 3'b010;
  localparam logic [2:0] FRC   = 3'b100;
  localparam logic [2:0] HI    = 3'b101;
  localparam logic [2:0] LO    = 3'b001;
  localparam logic [2:0] HIACK = 3'b111;
  localparam logic [2:0] LOACK = 3'b011;

  // ---------------- scoreboard ----------------
  logic [2:0] exp1_q[$];
  logic [2:0] exp4_q[$];
  string      lbl1_q[$];
  string      lbl4_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;

  logic [2:0] m_e;
  string      m_l;

  always @(posedge clk) begin
    #1;
    if (exp1_q.size() > 0) begin
      m_e = exp1_q.pop_front();
      m_l = lbl1_q.pop_front();
      n_checks++;
      if ({ir1, ack1, busy1} !== m_e) begin
        n_fail++;
        $display("FAIL %s (P=1) t=%0t: ir/ack/busy=%b%b%b required %b",
                 m_l, $time, ir1, ack1, busy1, m_e);
      end
    end
    if (exp4_q.size() > 0) begin
      m_e = exp4_q.pop_front();
      m_l = lbl4_q.pop_front();
      n_checks++;
      if ({ir4, ack4, busy4} !== m_e) begin
        n_fail++;
        $display("FAIL %s (P=4) t=%0t: ir/ack/busy=%b%b%b required %b",
                 m_l, $time, ir4, ack4, busy4, m_e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a falling edge with inputs already set; queues the outputs
  // expected after the next rising edge, then waits for the next falling edge.
  task automatic step(input bit c1, input logic [2:0] e1,
                      input bit c4, input logic [2:0] e4, input string l);
    if (c1) begin exp1_q.push_back(e1); lbl1_q.push_back(l); end
    if (c4) begin exp4_q.push_back(e4); lbl4_q.push_back(l); end
    @(negedge clk);
  endtask

  task automatic s1(input logic [2:0] e, input string l);
    step(1'b1, e, 1'b0, IDL, l);
  endtask

  task automatic s4(input logic [2:0] e, input string l);
    step(1'b0, IDL, 1'b1, e, l);
  endtask

  task automatic rep1(input int n, input logic [2:0] e, input string l);
    for (int i = 0; i < n; i++) s1(e, l);
  endtask

  task automatic rep4(input int n, input logic [2:0] e, input string l);
    for (int i = 0; i < n; i++) s4(e, l);
  endtask

  task automatic idle_step();
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    @(negedge clk);
    step(1'b1, IDL, 1'b1, IDL, "reset");
    step(1'b1, IDL, 1'b1, IDL, "reset");
    rst_n = 1'b1;
    s1(IDL, "idle after reset");

    // Held strobe: two captures, two acks, last word (3) wins.
    stb = 1'b1; val = 8'd2;
    s1(ACKI, "ack held 1");
    val = 8'd3;
    s1(ACKI, "ack held 2");
    stb = 1'b0;
    s1(IDL, "ack drop");
    s1(IDL, "idle transfer");

    // Value 3 at PRESCALE=1: 4 high, 4 low.
    en = 1'b1;
    s1(LO, "v3 start");
    rep1(4, HI, "v3 high a");
    rep1(4, LO, "v3 low a");
    rep1(4, HI, "v3 high b");
    rep1(4, LO, "v3 low b");

    // Write 7 in the middle of a high phase: that phase still ends at 4.
    rep1(2, HI, "v3 high c");
    stb = 1'b1; val = 8'd7;
    s1(HIACK, "wr7 ack");
    stb = 1'b0;
    s1(HI, "v3 high c tail");
    rep1(8, LO, "v7 low");
    rep1(8, HI, "v7 high");

    // Forced with enable low.
    en = 1'b0; frc = 1'b1;
    s1(IDL, "disable");
    rep1(3, FRC, "forced");

    // Enable and forced together: enable wins.
    en = 1'b1;
    s1(HI, "en+forced start");
    rep1(8, HI, "en+forced high");
    rep1(7, LO, "en+forced low");
    en = 1'b0; frc = 1'b0;
    s1(IDL, "drop both");
    rep1(2, IDL, "idle");

    // Strobe with value 5 on the same cycle enable rises.
    en = 1'b1; stb = 1'b1; val = 8'd5;
    s1(LOACK, "strobe+enable");
    stb = 1'b0;
    rep1(6, HI, "v5 high");
    rep1(6, LO, "v5 low");
    rep1(2, HI, "v5 high 2");
    stb = 1'b1; val = 8'd9;
    s1(HIACK, "pre-reset write");
    stb = 1'b0; en = 1'b0;

    // Asynchronous reset between clock edges while ir/ack/busy are all high.
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({ir1, ack1, busy1} !== IDL) begin
      n_fail++;
      $display("FAIL async reset (P=1) t=%0t: ir/ack/busy=%b%b%b required %b",
               $time, ir1, ack1, busy1, IDL);
    end
    n_checks++;
    if ({ir4, ack4, busy4} !== IDL) begin
      n_fail++;
      $display("FAIL async reset (P=4) t=%0t: ir/ack/busy=%b%b%b required %b",
               $time, ir4, ack4, busy4, IDL);
    end
    @(negedge clk);
    s1(IDL, "in reset");
    s1(IDL, "in reset");
    rst_n = 1'b1;
    s1(IDL, "post reset");

    // Pending write of 9 was discarded: value 0, period 2.
    en = 1'b1;
    s1(LO, "v0 start");
    for (int i = 0; i < 4; i++) begin
      s1(HI, "v0 high");
      s1(LO, "v0 low");
    end

    // PRESCALE=4 instance from a fresh reset.
    en = 1'b0;
    rst_n = 1'b0;
    step(1'b0, IDL, 1'b1, IDL, "p4 reset");
    step(1'b0, IDL, 1'b1, IDL, "p4 reset");
    rst_n = 1'b1;
    s4(IDL, "p4 idle");
    en = 1'b1;
    s4(LO, "p4 v0 start");
    rep4(4, HI, "p4 v0 high a");
    rep4(4, LO, "p4 v0 low a");
    rep4(4, HI, "p4 v0 high b");
    rep4(4, LO, "p4 v0 low b");
    en = 1'b0;
    idle_step();
    s4(IDL, "p4 stopped");
    stb = 1'b1; val = 8'd255;
    s4(ACKI, "p4 wr255 ack");
    stb = 1'b0;
    s4(IDL, "p4 idle transfer");
    en = 1'b1;
    s4(LO, "p4 v255 start");
    rep4(1024, HI, "p4 v255 high");
    rep4(1024, LO, "p4 v255 low");
    rep4(4, HI, "p4 v255 high 2");
    en = 1'b0;

    repeat (3) @(negedge clk);
    n_checks++;
    if (exp1_q.size() != 0 || exp4_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue drain: left %0d/%0d required 0/0",
               exp1_q.size(), exp4_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
